// File: rtl/kamus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kamus_pkg : shared types and constants for the kamus fetch unit
// Revision  : 1.0
// ---------------------------------------------------------------------------
package kamus_pkg;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_FLUSH = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/kamus_fetch_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kamus_fetch_fifo : small synchronous FIFO with flush, head view and count
// Revision         : 1.0
// ---------------------------------------------------------------------------
module kamus_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full buffer is legal only when the head leaves the same cycle
  assign w_do_pop  = pop && (r_count != '0) && !flush;
  assign w_do_push = push && ((r_count != CNT_W'(DEPTH)) || w_do_pop) && !flush;

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/kamus_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kamus_fetch : credit-limited instruction fetch with redirect/flush handling
// Revision    : 1.0
// ---------------------------------------------------------------------------
module kamus_fetch
  import kamus_pkg::*;
#(
  parameter int                 PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] BOOT_ADDR = PC_WIDTH'(DEFAULT_BOOT_ADDR),
  parameter int                 FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [31:0]         imem_rdata_i,
  output logic [31:0]         instr_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                instr_valid_o,
  input  logic                instr_ready_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]         r_discard, w_discard_nxt;
  logic [PC_WIDTH-1:0]      r_fetch_pc;
  logic [CNT_W-1:0]         w_fifo_count;
  logic [CNT_W-1:0]         w_outstanding;
  logic [PC_WIDTH-1:0]      w_tag_head;
  logic [32+PC_WIDTH-1:0]   w_fifo_head;
  logic                     w_credit;
  logic                     w_grant;
  logic                     w_fifo_push;
  logic                     w_fifo_pop;

  assign w_credit = ({1'b0, w_fifo_count} + {1'b0, w_outstanding}) < (CNT_W + 1)'(FIFO_DEPTH);
  // Gated by rst_ni so nothing is requested while reset is held
  assign imem_req_o  = rst_ni && !redirect_i && w_credit;
  assign imem_addr_o = r_fetch_pc;
  assign w_grant     = imem_req_o && imem_gnt_i;

  assign w_fifo_push = imem_rvalid_i && (r_state == FETCH_RUN) && !redirect_i;
  assign w_fifo_pop  = instr_valid_o && instr_ready_i && !redirect_i;

  assign instr_valid_o = (w_fifo_count != '0);
  assign instr_o       = instr_valid_o ? w_fifo_head[32+PC_WIDTH-1:PC_WIDTH] : 32'h0;
  assign pc_o          = instr_valid_o ? w_fifo_head[PC_WIDTH-1:0] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_fetch_pc <= BOOT_ADDR;
    else if (redirect_i)
      r_fetch_pc <= redirect_pc_i & ~PC_WIDTH'(3);
    else if (w_grant)
      r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= FETCH_RUN;
      r_discard <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  // Responses already in flight at a redirect belong to the old stream
  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    if (redirect_i) begin
      w_discard_nxt = w_outstanding - CNT_W'(imem_rvalid_i);
      w_state_nxt   = (w_discard_nxt != '0) ? FETCH_FLUSH : FETCH_RUN;
    end else if (r_state == FETCH_FLUSH && imem_rvalid_i) begin
      w_discard_nxt = r_discard - 1'b1;
      w_state_nxt   = (w_discard_nxt == '0) ? FETCH_RUN : FETCH_FLUSH;
    end
  end

  // Tag queue occupancy is the outstanding-request count
  kamus_fetch_fifo #(
    .WIDTH (PC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_q (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (1'b0),
    .push      (w_grant),
    .push_data (r_fetch_pc),
    .pop       (imem_rvalid_i),
    .head      (w_tag_head),
    .count     (w_outstanding)
  );

  kamus_fetch_fifo #(
    .WIDTH (32 + PC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_q (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (redirect_i),
    .push      (w_fifo_push),
    .push_data ({imem_rdata_i, w_tag_head}),
    .pop       (w_fifo_pop),
    .head      (w_fifo_head),
    .count     (w_fifo_count)
  );

  a_no_orphan_rvalid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> (w_outstanding != '0));

endmodule
`default_nettype wire
